cu_seq: RTL

//  Parametrised multicycle control unit; next generation of the single-opcode-table CU.

---
 rtl/cu_pkg.sv | 62 ++++++
 rtl/cu_seq_decode.sv | 38 +++
 rtl/cu_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types for the multicycle control unit: FSM state encoding,
// opcode constants, per-opcode operation info and the opcode decode function.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_OPRD   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDR  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00111;
    localparam logic [4:0] OP_ST   = 5'b01000;
    localparam logic [4:0] OP_CMP  = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b01010;
    localparam logic [4:0] OP_JG   = 5'b01011;
    localparam logic [4:0] OP_JL   = 5'b01100;
    localparam logic [4:0] OP_PUSH = 5'b01101;
    localparam logic [4:0] OP_POP  = 5'b01110;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    typedef enum logic [3:0] {
        K_NOP, K_LDR, K_ADD, K_ST, K_CMP, K_JMP,
        K_JG, K_JL, K_PUSH, K_POP, K_HLT, K_ILL
    } kind_t;

    // nops: operand read cycles, wr_reg: instruction has a WB step,
    // res_src: register write source (0 = ALU, 1 = memory)
    typedef struct packed {
        logic [1:0] nops;
        logic       wr_reg;
        logic       res_src;
        kind_t      kind;
    } op_info_t;

    localparam op_info_t ILL_INFO = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_ILL};

    function automatic op_info_t decode_op(input logic [4:0] opc);
        op_info_t r;
        r = ILL_INFO;
        case (opc)
            OP_NOP:  r = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_NOP};
            OP_LDR:  r = '{nops: 2'd1, wr_reg: 1'b1, res_src: 1'b1, kind: K_LDR};
            OP_ADD:  r = '{nops: 2'd2, wr_reg: 1'b1, res_src: 1'b0, kind: K_ADD};
            OP_ST:   r = '{nops: 2'd1, wr_reg: 1'b0, res_src: 1'b0, kind: K_ST};
            OP_CMP:  r = '{nops: 2'd2, wr_reg: 1'b0, res_src: 1'b0, kind: K_CMP};
            OP_JMP:  r = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_JMP};
            OP_JG:   r = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_JG};
            OP_JL:   r = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_JL};
            OP_PUSH: r = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_PUSH};
            OP_POP:  r = '{nops: 2'd0, wr_reg: 1'b1, res_src: 1'b1, kind: K_POP};
            OP_HLT:  r = '{nops: 2'd0, wr_reg: 1'b0, res_src: 1'b0, kind: K_HLT};
            default: r = ILL_INFO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cu_seq_decode.sv
// Combinational opcode decoder: opcode -> op_info_t.
// Opcode bits above the 5-bit table must be zero, otherwise the opcode is illegal.
// The operand count is clamped to the number of memory read channels.
module cu_seq_decode
    import cu_pkg::*;
#(
    parameter int OPC_W  = 5,
    parameter int MEM_CH = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output op_info_t         info
);
    localparam logic [1:0] NOPS_MAX = (MEM_CH >= 3) ? 2'd3 : 2'(MEM_CH);

    logic     hi_zero;
    op_info_t raw;

    generate
        if (OPC_W > 5) begin : g_wide
            assign hi_zero = ~|opcode[OPC_W-1:5];
        end else begin : g_narrow
            assign hi_zero = 1'b1;
        end
    endgenerate

    // table lookup, illegal on stray upper bits, operand count clamp
    always_comb begin
        raw = decode_op(opcode[4:0]);
        if (!hi_zero) begin
            raw = ILL_INFO;
        end
        info = raw;
        if (raw.nops > NOPS_MAX) begin
            info.nops = NOPS_MAX;
        end
    end

endmodule

// File: rtl/cu_seq.sv
// Multicycle control unit: FETCH/DECODE/OPRD/EXEC/WB sequencer with stall hold,
// latched compare flags, conditional branches, stack strobes, HALT and
// illegal-opcode detection. Strobes are decoded combinationally from the state
// and latched opcode and forced low while stalled or in reset.
// Optional debug ports D_STATE/D_SF/D_GF when CU_DEBUG_EN is defined.
module cu_seq
    import cu_pkg::*;
#(
    parameter int OPC_W  = 5,
    parameter int MEM_CH = 4,
    parameter int REG_CH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              s,
    input  logic              g,
    output logic [MEM_CH-1:0] memRE,
    output logic              memWE,
    output logic [REG_CH-1:0] regRE,
    output logic              regWE,
    output logic              resultSrc,
    output logic              instrWrite,
    output logic              pcEn,
    output logic              pcSrc,
    output logic              push,
    output logic              pop,
    output logic              illegal,
    output logic              halted
`ifdef CU_DEBUG_EN
    ,
    output logic [2:0]        D_STATE,
    output logic              D_SF,
    output logic              D_GF
`endif
);
    localparam int KW = $clog2(MEM_CH);

    state_t            state_reg;
    logic [OPC_W-1:0]  opc_reg;
    logic [KW-1:0]     k_reg;
    logic              sf_reg;
    logic              gf_reg;

    logic [OPC_W-1:0]  dec_opc;
    op_info_t          info;
    logic [KW-1:0]     k_last;
    logic              en;

    logic [MEM_CH-1:0] memre_c;
    logic [REG_CH-1:0] regre_c;
    logic memwe_c, regwe_c, rs_c, iw_c, pcen_c, pcsrc_c, push_c, pop_c, ill_c;

    // DECODE looks at the live opcode; every later step uses the latched one
    assign dec_opc = (state_reg == ST_DECODE) ? opcode : opc_reg;

    cu_seq_decode #(
        .OPC_W  (OPC_W),
        .MEM_CH (MEM_CH)
    ) u_decode (
        .opcode (dec_opc),
        .info   (info)
    );

    assign k_last = KW'(info.nops - 2'd1);

    // sequencer: state, operand counter, opcode latch and compare flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
            opc_reg   <= '0;
            k_reg     <= '0;
            sf_reg    <= 1'b0;
            gf_reg    <= 1'b0;
        end else if (!stall) begin
            case (state_reg)
                ST_FETCH: state_reg <= ST_DECODE;
                ST_DECODE: begin
                    opc_reg <= opcode;
                    k_reg   <= '0;
                    if (info.kind == K_HLT) begin
                        state_reg <= ST_HALT;
                    end else if (info.kind == K_ILL || info.kind == K_NOP) begin
                        state_reg <= ST_FETCH;
                    end else if (info.nops != 2'd0) begin
                        state_reg <= ST_OPRD;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_OPRD: begin
                    if (k_reg == k_last) begin
                        k_reg     <= '0;
                        state_reg <= ST_EXEC;
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                end
                ST_EXEC: begin
                    if (info.kind == K_CMP) begin
                        sf_reg <= s;
                        gf_reg <= g;
                    end
                    state_reg <= info.wr_reg ? ST_WB : ST_FETCH;
                end
                ST_WB:   state_reg <= ST_FETCH;
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    // raw strobe decode from state and operation info
    always_comb begin
        memre_c = '0;
        regre_c = '0;
        memwe_c = 1'b0;
        regwe_c = 1'b0;
        rs_c    = 1'b0;
        iw_c    = 1'b0;
        pcen_c  = 1'b0;
        pcsrc_c = 1'b0;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        ill_c   = 1'b0;
        case (state_reg)
            ST_FETCH: iw_c = 1'b1;
            ST_DECODE: begin
                pcen_c = 1'b1;
                ill_c  = (info.kind == K_ILL);
            end
            ST_OPRD: begin
                if (info.kind == K_ST) begin
                    regre_c = REG_CH'(1) << k_reg;
                end else begin
                    memre_c = MEM_CH'(1) << k_reg;
                end
            end
            ST_EXEC: begin
                case (info.kind)
                    K_ST:   memwe_c = 1'b1;
                    K_JMP: begin
                        pcen_c  = 1'b1;
                        pcsrc_c = 1'b1;
                    end
                    K_JG: begin
                        pcen_c  = gf_reg;
                        pcsrc_c = gf_reg;
                    end
                    K_JL: begin
                        pcen_c  = sf_reg;
                        pcsrc_c = sf_reg;
                    end
                    K_PUSH: push_c = 1'b1;
                    K_POP:  pop_c  = 1'b1;
                    default: ;
                endcase
            end
            ST_WB: begin
                regwe_c = info.wr_reg;
                rs_c    = info.res_src;
            end
            default: ;
        endcase
    end

    // reset also masks strobes so nothing partial leaks out while rst_n is low
    assign en         = rst_n & ~stall;
    assign memRE      = memre_c & {MEM_CH{en}};
    assign regRE      = regre_c & {REG_CH{en}};
    assign memWE      = memwe_c & en;
    assign regWE      = regwe_c & en;
    assign resultSrc  = rs_c    & en;
    assign instrWrite = iw_c    & en;
    assign pcEn       = pcen_c  & en;
    assign pcSrc      = pcsrc_c & en;
    assign push       = push_c  & en;
    assign pop        = pop_c   & en;
    assign illegal    = ill_c   & en;
    assign halted     = (state_reg == ST_HALT);

`ifdef CU_DEBUG_EN
    assign D_STATE = state_reg;
    assign D_SF    = sf_reg;
    assign D_GF    = gf_reg;
`endif

endmodule
